// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and constants for the instruction memory load/fetch controller
package imem_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } ctrl_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/imem_load_fetch_ctrl.sv
// rtl/imem_load_fetch_ctrl.sv - arbitrates instruction memory between a streaming loader and the fetch stage
module imem_load_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_dout
);

    ctrl_state_t       state;
    logic              loaded;
    logic [ADDR_W-1:0] wptr;
    logic              beat;
    logic              fetch_acc;

    assign load_ready  = (state == LOAD);
    assign fetch_ready = (state == RUN) && loaded && !load_start;
    assign beat        = (state == LOAD) && load_valid;
    assign fetch_acc   = fetch_req && fetch_ready;
    assign instr       = mem_dout;

    // The memory writes on every edge with R_W low, so write is asserted only on a real beat.
    always_comb begin
        mem_rw   = RW_READ;
        mem_addr = '0;
        mem_din  = '0;
        if (state == LOAD) begin
            mem_addr = wptr;
            if (beat) begin
                mem_rw  = RW_WRITE;
                mem_din = load_data;
            end
        end else if (fetch_acc) begin
            mem_addr = fetch_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            loaded      <= 1'b0;
            wptr        <= '0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            load_done   <= 1'b0;
            instr_valid <= fetch_acc;
            case (state)
                RUN: begin
                    if (load_start) begin
                        state    <= LOAD;
                        loaded   <= 1'b0;
                        load_err <= 1'b0;
                        wptr     <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (load_last) begin
                            state     <= RUN;
                            loaded    <= 1'b1;
                            load_done <= 1'b1;
                        end else if (wptr == {ADDR_W{1'b1}}) begin
                            // Image larger than memory: stop at the top instead of wrapping onto word 0.
                            state     <= RUN;
                            loaded    <= 1'b1;
                            load_done <= 1'b1;
                            load_err  <= 1'b1;
                        end else begin
                            wptr <= wptr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb/tb_imem_load_fetch_ctrl.sv - directed self-checking bench for imem_load_fetch_ctrl
module tb_imem_load_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        load_err;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_rw;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:65535];
    int          nwrites = 0;
    logic [15:0] last_waddr = '0;
    int          nvec = 0;
    int          nerr = 0;
    int          base;

    always #5 clk = ~clk;

    imem_load_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_err   (load_err),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instr      (instr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_rw     (mem_rw),
        .mem_dout   (mem_dout)
    );

    // 64K x 32 single-port memory, registered read
    always @(posedge clk) begin
        if (mem_rw == 1'b0) begin
            mem[mem_addr] <= mem_din;
            nwrites       <= nwrites + 1;
            last_waddr    <= mem_addr;
        end
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_mem_rw", 32'(mem_rw), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        rst = 1'b0;

        // Fetch with nothing loaded is refused
        fetch_req = 1'b1; fetch_addr = 16'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("noprog_fetch_ready", 32'(fetch_ready), 32'd0);
            chk("noprog_mem_rw", 32'(mem_rw), 32'd1);
            next_cycle();
        end
        chk("noprog_instr_valid", 32'(instr_valid), 32'd0);
        chk("noprog_nwrites", 32'(nwrites), 32'd0);

        // Four-beat load with a one-cycle gap
        idle_inputs();
        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 32'h11111111; #1;
        chk("ld_ready", 32'(load_ready), 32'd1);
        chk("ld_b0_rw", 32'(mem_rw), 32'd0);
        chk("ld_b0_addr", 32'(mem_addr), 32'd0);
        chk("ld_b0_din", mem_din, 32'h11111111);
        next_cycle();
        load_data = 32'h22222222; #1;
        chk("ld_b1_addr", 32'(mem_addr), 32'd1);
        next_cycle();
        load_valid = 1'b0; #1;
        chk("ld_gap_rw", 32'(mem_rw), 32'd1);
        chk("ld_gap_addr", 32'(mem_addr), 32'd2);
        next_cycle();
        load_valid = 1'b1; load_data = 32'h33333333; #1;
        chk("ld_b2_addr", 32'(mem_addr), 32'd2);
        next_cycle();
        load_data = 32'h44444444; load_last = 1'b1; #1;
        chk("ld_b3_addr", 32'(mem_addr), 32'd3);
        chk("ld_b3_rw", 32'(mem_rw), 32'd0);
        chk("ld_fetch_ready_during", 32'(fetch_ready), 32'd0);
        next_cycle();
        idle_inputs(); #1;
        chk("ld_done", 32'(load_done), 32'd1);
        chk("ld_err", 32'(load_err), 32'd0);
        chk("ld_fetch_ready_after", 32'(fetch_ready), 32'd1);
        chk("ld_ready_after", 32'(load_ready), 32'd0);
        chk("ld_nwrites", 32'(nwrites), 32'd4);
        chk("ld_mem2", mem[2], 32'h33333333);

        // Back-to-back fetches 0, 1, 3
        fetch_req = 1'b1; fetch_addr = 16'd0; #1;
        chk("f0_mem_addr", 32'(mem_addr), 32'd0);
        chk("f0_mem_rw", 32'(mem_rw), 32'd1);
        next_cycle();
        chk("f0_done_cleared", 32'(load_done), 32'd0);
        fetch_addr = 16'd1; #1;
        chk("f1_mem_addr", 32'(mem_addr), 32'd1);
        chk("f0_valid", 32'(instr_valid), 32'd1);
        chk("f0_instr", instr, 32'h11111111);
        next_cycle();
        fetch_addr = 16'd3; #1;
        chk("f1_valid", 32'(instr_valid), 32'd1);
        chk("f1_instr", instr, 32'h22222222);
        next_cycle();
        fetch_req = 1'b0; #1;
        chk("f3_valid", 32'(instr_valid), 32'd1);
        chk("f3_instr", instr, 32'h44444444);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        chk("idle_valid", 32'(instr_valid), 32'd0);

        // Fetch in N, load_start + fetch in N+1
        fetch_req = 1'b1; fetch_addr = 16'd2;
        next_cycle();
        load_start = 1'b1; fetch_addr = 16'd1; #1;
        chk("lsf_valid", 32'(instr_valid), 32'd1);
        chk("lsf_instr", instr, 32'h33333333);
        chk("lsf_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("lsf_mem_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        load_start = 1'b0; #1;
        chk("lsf_in_load", 32'(load_ready), 32'd1);
        chk("lsf_not_accepted", 32'(instr_valid), 32'd0);
        chk("lsf_fetch_ready_load", 32'(fetch_ready), 32'd0);
        next_cycle();

        // Overflow load: 65536 beats, no load_last
        base = nwrites;
        for (int k = 0; k < 65536; k++) begin
            load_valid = 1'b1;
            load_data  = 32'hA5A50000 | 32'(k);
            load_start = (k == 100);
            #1;
            if (k == 100) chk("ovf_start_ignored", 32'(mem_addr), 32'd100);
            if (k == 30000) chk("ovf_fetch_ready", 32'(fetch_ready), 32'd0);
            if (k == 65535) chk("ovf_last_addr", 32'(mem_addr), 32'h0000FFFF);
            next_cycle();
        end
        load_valid = 1'b0; load_start = 1'b0; fetch_addr = 16'd0; #1;
        chk("ovf_done", 32'(load_done), 32'd1);
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_ready", 32'(load_ready), 32'd0);
        chk("ovf_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("ovf_nwrites", 32'(nwrites - base), 32'd65536);
        chk("ovf_last_waddr", 32'(last_waddr), 32'h0000FFFF);
        next_cycle();
        fetch_addr = 16'hFFFF; #1;
        chk("ovf_instr0", instr, 32'hA5A50000);
        next_cycle();
        fetch_req = 1'b0; #1;
        chk("ovf_instr_top", instr, 32'hA5A5FFFF);
        chk("ovf_err_sticky", 32'(load_err), 32'd1);
        next_cycle();

        // Reset mid-load
        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0; load_valid = 1'b1; load_data = 32'hDEAD0000; #1;
        chk("rl_err_cleared", 32'(load_err), 32'd0);
        next_cycle();
        load_data = 32'hDEAD0001;
        next_cycle();
        rst = 1'b1; #1;
        chk("rl_ready", 32'(load_ready), 32'd0);
        chk("rl_mem_rw", 32'(mem_rw), 32'd1);
        chk("rl_fetch_ready", 32'(fetch_ready), 32'd0);
        next_cycle();
        rst = 1'b0; idle_inputs();
        fetch_req = 1'b1; fetch_addr = 16'd0; #1;
        chk("rl_fetch_ready_after", 32'(fetch_ready), 32'd0);
        next_cycle();
        chk("rl_instr_valid", 32'(instr_valid), 32'd0);
        fetch_req = 1'b0; load_start = 1'b1;
        next_cycle();
        load_start = 1'b0; load_valid = 1'b1; load_last = 1'b1; load_data = 32'h0000BEEF;
        next_cycle();
        idle_inputs(); fetch_req = 1'b1; #1;
        chk("rl_reload_done", 32'(load_done), 32'd1);
        chk("rl_reload_ready", 32'(fetch_ready), 32'd1);
        next_cycle();
        fetch_req = 1'b0; #1;
        chk("rl_reload_instr", instr, 32'h0000BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/imem_load_fetch_ctrl.md
# imem_load_fetch_ctrl

Sequencing controller for the 64K x 32 single-port instruction memory (registered read, write on `clk` edge when R_W=0). It owns the memory's address, data-in and R_W lines. It arbitrates between a streaming program loader, which writes the image from address 0, and the fetch stage, which issues one read per cycle once a program is loaded. Sits between the boot/loader interface, the PC/fetch logic and the instruction memory.

## Interface
- ADDR_W, 16, memory address width (depth 2^ADDR_W words)
- DATA_W, 32, instruction word width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse: begin new program load at address 0
- load_valid  in  1  loader beat valid
- load_data  in  DATA_W  loader word
- load_last  in  1  marks final beat of image
- load_ready  out  1  controller accepts beat (beat transfers on load_valid & load_ready)
- load_done  out  1  one-cycle pulse after final write
- load_err  out  1  sticky: image overflowed memory; cleared by load_start
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  request accepted when fetch_req & fetch_ready
- instr_valid  out  1  instr holds the word for the request accepted previous cycle
- instr  out  DATA_W  fetched instruction (= mem_dout)
- mem_addr  out  ADDR_W  to memory address
- mem_din  out  DATA_W  to memory DataIn
- mem_rw  out  1  to memory R_W (1 read, 0 write)
- mem_dout  in  DATA_W  from memory DataOut

## Operation
- States: RUN, LOAD. Flag `loaded` (program present).
- RUN:
  - fetch_ready = loaded & !load_start.
  - On accepted fetch: mem_addr = fetch_addr, mem_rw = 1.
  - Otherwise mem_addr = 0, mem_din = 0, mem_rw = 1. The memory writes on every edge with R_W=0, so mem_rw is 0 only during an accepted load beat. Idle cycles are reads.
  - load_start → LOAD; clear loaded and load_err; write pointer wptr = 0.
- LOAD:
  - load_ready = 1 and fetch_ready = 0.
  - On a beat: mem_rw = 0, mem_addr = wptr, mem_din = load_data, then wptr++.
  - Cycles with no beat: mem_rw = 1, mem_addr = wptr (harmless read).
  - load_start in LOAD is ignored.
  - Beat with load_last → RUN, loaded = 1, load_done pulses the next cycle.
  - Beat at wptr = 2^ADDR_W-1 without load_last: wptr does not wrap. → RUN, loaded = 1, load_err = 1, load_done pulses.
- instr_valid is registered: it is 1 in the cycle after an accepted fetch and 0 otherwise. instr is passed through combinationally from mem_dout.
- A fetch accepted in the cycle before load_start still returns instr_valid in the following cycle, even though the controller is then in LOAD.
- Reset (any time, including mid-load): state = RUN, loaded = 0, wptr = 0. Memory contents are undefined, and a partial image is not usable.

## Timing
- Reset values:
  - load_ready 0, load_done 0, load_err 0, fetch_ready 0, instr_valid 0.
  - mem_rw 1, mem_addr 0, mem_din 0.
- Fetch latency: accepted in cycle N, instr_valid = 1 and instr valid in cycle N+1. Throughput is 1 fetch per cycle, back-to-back.
- Load throughput: 1 word per cycle. load_ready is combinational from state.
- load_done is asserted in the cycle after the final beat. fetch_ready first rises in that same cycle.
- load_start and fetch_req in the same RUN cycle: load wins, and the fetch is not accepted.
- mem_addr, mem_din and mem_rw are combinational from state, wptr and the inputs. They must be stable before the rising edge of clk.

## Structure
- Package imem_ctrl_pkg holds:
  - state enum {RUN, LOAD};
  - RW_READ = 1'b1 and RW_WRITE = 1'b0;
  - default ADDR_W and DATA_W.
- No sub-module. The state register, wptr counter and output mux are inline.
- The instruction memory is instantiated alongside this block by the parent, not inside it.

## Test plan
- Reset, then idle → all outputs at reset values. fetch_req = 1 gives fetch_ready = 0, instr_valid stays 0, and mem_rw never drops to 0.
- load_start, then beats 0x11111111, 0x22222222, (1-cycle gap), 0x33333333, 0x44444444 (last) → memory writes at addresses 0..3 with mem_rw = 0 only on the 4 beat cycles. load_done is asserted 1 cycle after the 4th beat, load_err = 0.
- After that load, fetch addresses 0, 1, 3 on consecutive cycles → instr_valid is high for 3 consecutive cycles with 0x11111111, 0x22222222, 0x44444444.
- Fetch addr 2 accepted in cycle N, and load_start with fetch_req addr 1 in cycle N+1 → instr = 0x33333333 valid in N+1. The addr-1 fetch is not accepted, the controller is in LOAD in N+2, and fetch_ready = 0 until load_done.
- Load 65536 beats with no load_last → last write at 0xFFFF, then load_err = 1, load_done pulses, and wptr does not wrap (address 0 is not rewritten).
- Assert rst after 2 load beats → the controller immediately returns to RUN with loaded = 0, and fetch_ready = 0 until a new complete load.
